// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC generation, instruction bus fetch and in-order delivery to IF/ID
// FETCH_PREFETCH_EN: two fetches in flight or buffered (back-to-back issue); undefined: one.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [2:0]  hold_flag_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

`ifdef FETCH_PREFETCH_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [2:0]  HOLD_PC = 3'd1;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [1:0][31:0]  aq_q, aq_d;
    logic [1:0][31:0]  iq_addr_q, iq_addr_d;
    logic [1:0][31:0]  iq_data_q, iq_data_d;
    logic [1:0]        out_q, out_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        disc_q, disc_d;
    logic              pend_q, pend_d;

    logic              rv_eff;
    logic              pop;
    logic [2:0]        avail;
    logic              new_ok;
    logic              req;
    logic              fire;
    logic              aq_wr;
    logic              iq_wr;

    // The slot freed by this cycle's pop is credited so a zero-wait bus sustains one word per cycle.
    always_comb begin
        rv_eff = ibus_rvalid_i && (out_q != 2'd0);
        pop    = (cnt_q != 2'd0) && (hold_flag_i <= HOLD_PC) && !jump_flag_i;
        avail  = {1'b0, out_q} + {1'b0, cnt_q} - {2'b00, pop};
        new_ok = (hold_flag_i < HOLD_PC) && (avail < 3'(CAP));
        req    = (state_q != ST_BOOT) && !jump_flag_i && (pend_q || new_ok);
        fire   = req && ibus_gnt_i;
        aq_wr  = out_q[0] && !rv_eff;
        iq_wr  = cnt_q[0] && !pop;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        aq_d      = aq_q;
        iq_addr_d = iq_addr_q;
        iq_data_d = iq_data_q;
        out_d     = out_q;
        cnt_d     = cnt_q;
        disc_d    = disc_q;
        pend_d    = req && !ibus_gnt_i;

        if (rv_eff) begin
            aq_d[0] = aq_q[1];
            out_d   = out_q - 2'd1;
        end
        if (fire) begin
            aq_d[aq_wr] = pc_q;
            pc_d        = pc_q + 32'd4;
            out_d       = out_d + 2'd1;
        end

        if (pop) begin
            iq_addr_d[0] = iq_addr_q[1];
            iq_data_d[0] = iq_data_q[1];
            cnt_d        = cnt_q - 2'd1;
        end
        if (rv_eff) begin
            if (disc_q != 2'd0) begin
                disc_d = disc_q - 2'd1;
            end else begin
                iq_addr_d[iq_wr] = aq_q[0];
                iq_data_d[iq_wr] = ibus_rdata_i;
                cnt_d            = cnt_d + 2'd1;
            end
        end

        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            ST_DRAIN: if (disc_d == 2'd0) state_d = ST_RUN;
            default:  state_d = ST_BOOT;
        endcase

        // Whatever is still outstanding after this cycle's response belongs to the old stream.
        if (jump_flag_i) begin
            pc_d    = jump_addr_i & ~32'd3;
            cnt_d   = 2'd0;
            disc_d  = out_d;
            state_d = (out_d != 2'd0) ? ST_DRAIN : ST_RUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_ADDR;
            aq_q      <= '0;
            iq_addr_q <= '0;
            iq_data_q <= '0;
            out_q     <= 2'd0;
            cnt_q     <= 2'd0;
            disc_q    <= 2'd0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            aq_q      <= aq_d;
            iq_addr_q <= iq_addr_d;
            iq_data_q <= iq_data_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            disc_q    <= disc_d;
            pend_q    <= pend_d;
        end
    end

    assign ibus_req_o  = req;
    assign ibus_addr_o = pc_q;
    assign inst_o      = ((cnt_q != 2'd0) && !jump_flag_i) ? iq_data_q[0] : NOP;
    assign inst_addr_o = ((cnt_q != 2'd0) && !jump_flag_i) ? iq_addr_q[0] : RESET_ADDR;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] NOP        = 32'h0000_0013;
`ifdef FETCH_PREFETCH_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  hold;
    logic        jump;
    logic [31:0] jaddr;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] inst;
    logic [31:0] inst_addr;

    pc_fetch_unit #(.RESET_ADDR(RESET_ADDR)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .hold_flag_i  (hold),
        .jump_flag_i  (jump),
        .jump_addr_i  (jaddr),
        .ibus_req_o   (req),
        .ibus_addr_o  (addr),
        .ibus_gnt_i   (gnt),
        .ibus_rvalid_i(rvalid),
        .ibus_rdata_i (rdata),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        int          due;
    } resp_t;

    resp_t       pend[$];
    logic [63:0] sb[$];
    int          stale;
    logic [31:0] exp_pc;
    int          cyc;
    logic        prev_pending;
    logic [31:0] prev_addr;
    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;

    int          gnt_pct, lat_min, lat_max, jump_pm, hold_force;
    logic        hold_rand;
    logic        jump_force;
    logic [31:0] jump_target;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {1'b1, a[30:0] ^ {a[14:0], a[30:15]}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic sample();
        resp_t r;
        if (jump) begin
            chk("jump_req", 32'(req), 32'd1 - 32'd1);
            chk("jump_inst", inst, NOP);
        end else if (prev_pending) begin
            chk("pending_req", 32'(req), 32'd1);
            chk("pending_addr", addr, prev_addr);
        end else if (hold >= 3'd1) begin
            chk("hold_no_req", 32'(req), 32'd0);
        end
        if (rvalid && pend.size() > 0) begin
            r = pend.pop_front();
            if (stale > 0) stale--;
            else if (!jump) sb.push_back({r.a, mem(r.a)});
        end
        if (req && gnt) begin
            chk("issue_addr", addr, exp_pc);
            r.a = addr;
            r.due = cyc + int'($urandom_range(lat_max, lat_min));
            pend.push_back(r);
            exp_pc = exp_pc + 32'd4;
        end
        if (jump) begin
            sb.delete();
            stale  = pend.size();
            exp_pc = jaddr & ~32'd3;
        end
        prev_pending = req && !gnt && !jump;
        prev_addr    = addr;
    endtask

    task automatic step();
        @(posedge clk);
        chk("cap_bound", 32'((pend.size() + sb.size()) <= CAP), 32'd1);
        #1;
        cyc++;
        gnt = ($urandom_range(99) < gnt_pct);
        if (hold_force >= 0) hold = 3'(hold_force);
        else if (hold_rand && $urandom_range(3) == 0) hold = 3'($urandom_range(3));
        else hold = 3'd0;
        jump  = jump_force || ($urandom_range(999) < jump_pm);
        jaddr = jump_force ? jump_target : $urandom;
        rvalid = 1'b0;
        rdata  = $urandom;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem(pend[0].a);
        end
        @(negedge clk);
        sample();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; jump = 1'b0; hold = 3'd0;
        pend.delete();
        sb.delete();
        stale = 0;
        exp_pc = RESET_ADDR;
        prev_pending = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_addr", addr, RESET_ADDR);
        chk("rst_inst", inst, NOP);
        chk("rst_inst_addr", inst_addr, RESET_ADDR);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        gnt    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("boot_req", 32'(req), 32'd0);
        chk("boot_inst", inst, NOP);
    endtask

    logic [31:0] prev_inst;
    logic        prev_held;

    // Delivery monitor: every instruction the IF/ID stage consumes must be the next scoreboard entry.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            prev_held = 1'b0;
        end else begin
            if (inst === NOP) chk("idle_addr", inst_addr, RESET_ADDR);
            if (!jump && hold >= 3'd2 && prev_held && prev_inst !== NOP)
                chk("held_inst", inst, prev_inst);
            if (!jump && hold <= 3'd1 && inst !== NOP) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL deliver_unexpected actual=%h@%h required=none at cycle %0d",
                             inst, inst_addr, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("deliver_addr", inst_addr, e[63:32]);
                    chk("deliver_data", inst, e[31:0]);
                end
                delivered++;
            end
            prev_held = !jump && hold >= 3'd2;
            prev_inst = inst;
        end
    end

    initial begin
        int d0;
        rst_n = 1'b0; hold = 3'd0; jump = 1'b0; jaddr = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        cyc = 0; stale = 0; exp_pc = RESET_ADDR; prev_pending = 1'b0; prev_addr = '0;
        prev_inst = NOP; prev_held = 1'b0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; jump_pm = 0; hold_force = 0;
        hold_rand = 1'b0; jump_force = 1'b0; jump_target = '0;

        do_reset();
        step();
        chk("first_req", 32'(req), 32'd1);
        chk("first_addr", addr, RESET_ADDR);
        repeat (9) step();
        d0 = delivered;
        repeat (20) step();
        chk("throughput", 32'(delivered - d0), (CAP == 2) ? 32'd20 : 32'd10);

        lat_min = 2; lat_max = 2;
        repeat (10) step();
        jump_force = 1'b1; jump_target = 32'h0000_1002;
        step();
        jump_force = 1'b0;
        lat_min = 1; lat_max = 1;
        step();
        chk("post_jump_addr", addr, 32'h0000_1000);
        repeat (10) step();

        hold_force = 2;
        repeat (3) step();
        hold_force = 0;
        repeat (6) step();

        gnt_pct = 0;
        repeat (2) step();
        for (int i = 0; i < 4; i++) begin
            hold_force = (i % 2 == 0) ? 1 : 0;
            step();
            chk("withheld_req", 32'(req), 32'd1);
        end
        hold_force = 0; gnt_pct = 100;
        repeat (4) step();

        jump_force = 1'b1; jump_target = 32'hFFFF_FFF8;
        step();
        jump_force = 1'b0;
        repeat (10) step();

        gnt_pct = 70; lat_min = 1; lat_max = 3; jump_pm = 20; hold_force = -1; hold_rand = 1'b1;
        d0 = delivered;
        repeat (700) step();
        do_reset();
        repeat (700) step();
        chk("random_progress", 32'((delivered - d0) > 50), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
